// File: rtl/sobel_ctrl_pkg.sv
// sobel_ctrl_pkg
// Shared definitions for the Sobel window controller slice. It holds the
// window FSM state encoding and the default geometry of the video stream.
// Parameters of sobel_window_ctrl default to these constants.
package sobel_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int DEF_Y_DEPTH    = 8;
    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_FILTER_LAT = 2;

endpackage

// File: rtl/sobel_line_ram.sv
// sobel_line_ram
// Simple dual-port line buffer of 2^ADDR_W words of Y_DEPTH bits.
// The read port is registered. On a same-address read and write in one
// cycle the read returns the old word (read-before-write).
// Ports:
//   r_pclk     pixel clock
//   i_rd_en    read strobe; o_rd_data holds its value when low
//   i_rd_addr  read address
//   o_rd_data  registered read data
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
// Contents are not reset.
module sobel_line_ram #(
    parameter int ADDR_W  = 10,
    parameter int Y_DEPTH = 8
) (
    input  logic               r_pclk,
    input  logic               i_rd_en,
    input  logic [ADDR_W-1:0]  i_rd_addr,
    output logic [Y_DEPTH-1:0] o_rd_data,
    input  logic               i_wr_en,
    input  logic [ADDR_W-1:0]  i_wr_addr,
    input  logic [Y_DEPTH-1:0] i_wr_data
);

    logic [Y_DEPTH-1:0] mem [2**ADDR_W];
    logic [Y_DEPTH-1:0] rd_data_q;

    // Both ports update with non-blocking assignments, so a read of the
    // address being written sees the word from before this edge.
    always_ff @(posedge r_pclk) begin
        if (i_rd_en) begin
            rd_data_q <= mem[i_rd_addr];
        end
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = rd_data_q;

endmodule

// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl
// Turns a streaming luma input into the three vertically aligned taps of a
// 3x3 window (rows y-2, y-1, y) for sobel_scharr. Owns the two line buffers
// and the row/column counters, gates window validity at the top border and
// delays the window markers by FILTER_LAT so they line up with the filter.
//
// Ports:
//   r_pclk, r_arst          pixel clock, asynchronous active-high reset
//   i_valid, i_sof, i_pixel input pixel strobe, start of frame, luma
//   o_pixel_11_11           top tap    (row y-2)
//   o_pixel_00_11           middle tap (row y-1)
//   o_pixel_01_11           bottom tap (row y)
//   o_win_valid             taps valid
//   o_valid, o_sof, o_eol   window valid / first window / last window of
//                           line, delayed FILTER_LAT cycles
//   o_ovf                   pulse: pixel offered outside a frame, dropped
//   o_busy                  a frame is in progress
//
// Build option SOBEL_ZERO_PAD_EN: emit windows for every row, zeroing the
// taps that would fall above the frame, and mark the frame start at (0,0).
//
// Pipeline for a pixel accepted at edge N:
//   N   : counters update, pixel and its window flags captured
//   N+1 : line buffer read/write, current pixel delayed
//   N+2 : taps and o_win_valid registered
//   N+2+FILTER_LAT : o_valid / o_sof / o_eol
module sobel_window_ctrl
    import sobel_ctrl_pkg::*;
#(
    parameter int Y_DEPTH    = DEF_Y_DEPTH,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FILTER_LAT = DEF_FILTER_LAT
) (
    input  logic               r_pclk,
    input  logic               r_arst,
    input  logic               i_valid,
    input  logic               i_sof,
    input  logic [Y_DEPTH-1:0] i_pixel,
    output logic [Y_DEPTH-1:0] o_pixel_11_11,
    output logic [Y_DEPTH-1:0] o_pixel_00_11,
    output logic [Y_DEPTH-1:0] o_pixel_01_11,
    output logic               o_win_valid,
    output logic               o_valid,
    output logic               o_sof,
    output logic               o_eol,
    output logic               o_ovf,
    output logic               o_busy
);

    localparam int ROW_W = $clog2(V_ACTIVE + 1);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(V_ACTIVE - 1);
`ifdef SOBEL_ZERO_PAD_EN
    localparam logic [ROW_W-1:0]  FIRST_WIN_ROW = '0;
`else
    localparam logic [ROW_W-1:0]  FIRST_WIN_ROW = ROW_W'(2);
`endif

    // Frame sequencing
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic                lb_sel_q, lb_sel_d;
    logic                busy_q, busy_d;
    logic                ovf_q, ovf_d;

    logic                accept;
    logic                restart;
    logic [ADDR_W-1:0]   col_cur;
    logic [ROW_W-1:0]    row_cur;
    logic                win_cur;

    // Capture stage (edge N)
    logic                in_valid_q, in_valid_d;
    logic                in_win_q, in_win_d;
    logic                in_sof_q, in_sof_d;
    logic                in_eol_q, in_eol_d;
    logic                in_sel_q, in_sel_d;
    logic [ADDR_W-1:0]   in_col_q, in_col_d;
    logic [Y_DEPTH-1:0]  in_pix_q, in_pix_d;

    // RAM stage (edge N+1)
    logic                s1_win_q, s1_win_d;
    logic                s1_sof_q, s1_sof_d;
    logic                s1_eol_q, s1_eol_d;
    logic                s1_sel_q, s1_sel_d;
    logic [Y_DEPTH-1:0]  s1_pix_q, s1_pix_d;

`ifdef SOBEL_ZERO_PAD_EN
    logic                in_row0_q, in_row0_d;
    logic                in_row1_q, in_row1_d;
    logic                s1_row0_q, s1_row0_d;
    logic                s1_row1_q, s1_row1_d;
`endif

    // Output stage (edge N+2) and marker delay line
    logic                win_valid_q, win_valid_d;
    logic                win_sof_q, win_sof_d;
    logic                win_eol_q, win_eol_d;
    logic [Y_DEPTH-1:0]  tap_top_q, tap_top_d;
    logic [Y_DEPTH-1:0]  tap_mid_q, tap_mid_d;
    logic [Y_DEPTH-1:0]  tap_bot_q, tap_bot_d;
    logic [FILTER_LAT-1:0][2:0] mk_q, mk_d;

    logic [Y_DEPTH-1:0]  ram0_rd, ram1_rd;
    logic [Y_DEPTH-1:0]  top_sel, mid_sel;

    // lb_sel = 0: RAM0 plays LB_A (row y-1), RAM1 plays LB_B (row y-2).
    // The pixel being accepted always overwrites the LB_B word it just read.
    sobel_line_ram #(.ADDR_W(ADDR_W), .Y_DEPTH(Y_DEPTH)) u_ram0 (
        .r_pclk    (r_pclk),
        .i_rd_en   (in_valid_q),
        .i_rd_addr (in_col_q),
        .o_rd_data (ram0_rd),
        .i_wr_en   (in_valid_q & in_sel_q),
        .i_wr_addr (in_col_q),
        .i_wr_data (in_pix_q)
    );

    sobel_line_ram #(.ADDR_W(ADDR_W), .Y_DEPTH(Y_DEPTH)) u_ram1 (
        .r_pclk    (r_pclk),
        .i_rd_en   (in_valid_q),
        .i_rd_addr (in_col_q),
        .o_rd_data (ram1_rd),
        .i_wr_en   (in_valid_q & ~in_sel_q),
        .i_wr_addr (in_col_q),
        .i_wr_data (in_pix_q)
    );

    // Next-state logic for the whole controller. An SOF pixel is treated as
    // pixel (0,0) in any state, so an early or repeated SOF restarts the
    // frame and an SOF straight after the last pixel needs no bubble.
    always_comb begin
        restart = i_valid & i_sof;
        accept  = i_valid & (i_sof | (state_q == ACTIVE));
        col_cur = restart ? '0 : col_q;
        row_cur = restart ? '0 : row_q;
        win_cur = (row_cur >= FIRST_WIN_ROW);

        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        lb_sel_d = lb_sel_q;
        if (accept) begin
            state_d = ACTIVE;
            row_d   = row_cur;
            if (col_cur == COL_LAST) begin
                col_d    = '0;
                lb_sel_d = ~lb_sel_q;
                if (row_cur == ROW_LAST) begin
                    row_d   = '0;
                    state_d = DONE;
                end else begin
                    row_d = row_cur + ROW_W'(1);
                end
            end else begin
                col_d = col_cur + ADDR_W'(1);
            end
        end
        busy_d = (state_d == ACTIVE);
        ovf_d  = i_valid & ~i_sof & (state_q != ACTIVE);

        in_valid_d = accept;
        in_win_d   = accept & win_cur;
        in_sof_d   = accept & win_cur & (col_cur == '0) & (row_cur == FIRST_WIN_ROW);
        in_eol_d   = accept & win_cur & (col_cur == COL_LAST);
        in_sel_d   = in_sel_q;
        in_col_d   = in_col_q;
        in_pix_d   = in_pix_q;
        if (accept) begin
            in_sel_d = lb_sel_q;
            in_col_d = col_cur;
            in_pix_d = i_pixel;
        end

        s1_win_d = in_win_q;
        s1_sof_d = in_sof_q;
        s1_eol_d = in_eol_q;
        s1_sel_d = in_valid_q ? in_sel_q : s1_sel_q;
        s1_pix_d = in_valid_q ? in_pix_q : s1_pix_q;

        mid_sel = s1_sel_q ? ram1_rd : ram0_rd;
        top_sel = s1_sel_q ? ram0_rd : ram1_rd;

`ifdef SOBEL_ZERO_PAD_EN
        // Rows above the frame read as black instead of stale buffer data.
        in_row0_d = accept ? (row_cur == '0) : in_row0_q;
        in_row1_d = accept ? (row_cur == ROW_W'(1)) : in_row1_q;
        s1_row0_d = in_valid_q ? in_row0_q : s1_row0_q;
        s1_row1_d = in_valid_q ? in_row1_q : s1_row1_q;
        if (s1_row0_q) begin
            top_sel = '0;
            mid_sel = '0;
        end else if (s1_row1_q) begin
            top_sel = '0;
        end
`endif

        // Taps only move on a real window so they hold between windows.
        win_valid_d = s1_win_q;
        win_sof_d   = s1_sof_q;
        win_eol_d   = s1_eol_q;
        tap_top_d   = s1_win_q ? top_sel  : tap_top_q;
        tap_mid_d   = s1_win_q ? mid_sel  : tap_mid_q;
        tap_bot_d   = s1_win_q ? s1_pix_q : tap_bot_q;

        // Marker delay line runs every cycle, matching the filter latency.
        mk_d[0] = {win_valid_q, win_sof_q, win_eol_q};
        for (int i = 1; i < FILTER_LAT; i++) begin
            mk_d[i] = mk_q[i-1];
        end
    end

    // All controller state, cleared asynchronously. RAM words are not reset.
    always_ff @(posedge r_pclk or posedge r_arst) begin
        if (r_arst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            lb_sel_q    <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_valid_q  <= 1'b0;
            in_win_q    <= 1'b0;
            in_sof_q    <= 1'b0;
            in_eol_q    <= 1'b0;
            in_sel_q    <= 1'b0;
            in_col_q    <= '0;
            in_pix_q    <= '0;
            s1_win_q    <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_eol_q    <= 1'b0;
            s1_sel_q    <= 1'b0;
            s1_pix_q    <= '0;
`ifdef SOBEL_ZERO_PAD_EN
            in_row0_q   <= 1'b0;
            in_row1_q   <= 1'b0;
            s1_row0_q   <= 1'b0;
            s1_row1_q   <= 1'b0;
`endif
            win_valid_q <= 1'b0;
            win_sof_q   <= 1'b0;
            win_eol_q   <= 1'b0;
            tap_top_q   <= '0;
            tap_mid_q   <= '0;
            tap_bot_q   <= '0;
            mk_q        <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            lb_sel_q    <= lb_sel_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
            in_valid_q  <= in_valid_d;
            in_win_q    <= in_win_d;
            in_sof_q    <= in_sof_d;
            in_eol_q    <= in_eol_d;
            in_sel_q    <= in_sel_d;
            in_col_q    <= in_col_d;
            in_pix_q    <= in_pix_d;
            s1_win_q    <= s1_win_d;
            s1_sof_q    <= s1_sof_d;
            s1_eol_q    <= s1_eol_d;
            s1_sel_q    <= s1_sel_d;
            s1_pix_q    <= s1_pix_d;
`ifdef SOBEL_ZERO_PAD_EN
            in_row0_q   <= in_row0_d;
            in_row1_q   <= in_row1_d;
            s1_row0_q   <= s1_row0_d;
            s1_row1_q   <= s1_row1_d;
`endif
            win_valid_q <= win_valid_d;
            win_sof_q   <= win_sof_d;
            win_eol_q   <= win_eol_d;
            tap_top_q   <= tap_top_d;
            tap_mid_q   <= tap_mid_d;
            tap_bot_q   <= tap_bot_d;
            mk_q        <= mk_d;
        end
    end

    assign o_pixel_11_11 = tap_top_q;
    assign o_pixel_00_11 = tap_mid_q;
    assign o_pixel_01_11 = tap_bot_q;
    assign o_win_valid   = win_valid_q;
    assign o_valid       = mk_q[FILTER_LAT-1][2];
    assign o_sof         = mk_q[FILTER_LAT-1][1];
    assign o_eol         = mk_q[FILTER_LAT-1][0];
    assign o_ovf         = ovf_q;
    assign o_busy        = busy_q;

endmodule
